// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register file's single write port between two sources:
//   - the in-order writeback stage (pipe_*), which normally wins the port;
//   - a long-latency unit (lu_*), whose late results wait in a small circular
//     FIFO. They drain into idle port cycles, and once the FIFO head has waited
//     MAX_WAIT cycles the block raises stall_req and takes the port itself.
// A pending-register lookup (q_num1/q_num2 -> q_hit1/q_hit2) lets decode spot
// RAW/WAW hazards against results that are buffered or being stored this cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pipe_we/num/data          writeback-stage write request
//   lu_valid/num/data         long-latency result offered to the FIFO
//   lu_ready                  FIFO can accept a result this cycle
//   q_num1/q_num2             decode register queries
//   q_hit1/q_hit2             query matches a pending long-latency write
//   stall_req                 pipeline must hold this cycle
//   fifo_cnt                  FIFO occupancy, 0..DEPTH
//   WriteBackNum/Reg/Data     register-file write address, enable, data
//
// Every output is combinational from the registered state and the current
// inputs; the register file commits at the same clk edge (zero latency).
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_num,
    input  logic [31:0]              pipe_data,
    input  logic                     lu_valid,
    input  logic [4:0]               lu_num,
    input  logic [31:0]              lu_data,
    output logic                     lu_ready,
    input  logic [4:0]               q_num1,
    input  logic [4:0]               q_num2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [4:0]               WriteBackNum,
    output logic                     WriteBackReg,
    output logic [31:0]              WriteBackData
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    num_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;

    logic             fifo_empty;
    logic             store;
    logic             pipe_ok;
    logic             grant_pipe;
    logic             grant_fifo;
    logic [DEPTH-1:0] entry_valid;
    logic             mem_hit1;
    logic             mem_hit2;

    // Handshake, stall and grant decisions. A handshake with lu_num == 0 is
    // accepted but never stored, since x0 writes are meaningless. lu_ready
    // looks only at the current count, so a full FIFO refuses a result even
    // in a cycle where its head drains.
    always_comb begin
        fifo_empty = (count == '0);
        lu_ready   = !rst && (count < CW'(DEPTH));
        store      = lu_valid && lu_ready && (lu_num != 5'd0);
        stall_req  = !rst && !fifo_empty && (wait_cnt == WW'(MAX_WAIT));
        pipe_ok    = pipe_we && (pipe_num != 5'd0);
        grant_fifo = !rst && !fifo_empty && (stall_req || !pipe_ok);
        grant_pipe = !rst && !stall_req && pipe_ok;
        fifo_cnt   = rst ? '0 : count;
    end

    // Write-port mux. An enqueued result only reaches the port from the head
    // on a later cycle; there is no bypass from lu_* to the port.
    always_comb begin
        WriteBackReg  = 1'b0;
        WriteBackNum  = 5'd0;
        WriteBackData = 32'd0;
        if (grant_fifo) begin
            WriteBackReg  = 1'b1;
            WriteBackNum  = num_mem[head];
            WriteBackData = data_mem[head];
        end else if (grant_pipe) begin
            WriteBackReg  = 1'b1;
            WriteBackNum  = pipe_num;
            WriteBackData = pipe_data;
        end
    end

    // Pending-register lookup. A slot holds a live entry when its distance
    // from head (modulo DEPTH) is below count. The result being stored this
    // cycle also counts, so decode cannot slip past it in the same cycle.
    always_comb begin
        entry_valid = '0;
        mem_hit1    = 1'b0;
        mem_hit2    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, AW'(AW'(i) - head)} < count);
            if (entry_valid[i] && (num_mem[i] == q_num1)) begin
                mem_hit1 = 1'b1;
            end
            if (entry_valid[i] && (num_mem[i] == q_num2)) begin
                mem_hit2 = 1'b1;
            end
        end
        q_hit1 = !rst && (q_num1 != 5'd0) &&
                 (mem_hit1 || (store && (lu_num == q_num1)));
        q_hit2 = !rst && (q_num2 != 5'd0) &&
                 (mem_hit2 || (store && (lu_num == q_num2)));
    end

    // FIFO pointers, occupancy and head age. The age restarts whenever a new
    // head is exposed (FIFO was empty or the head just drained) and otherwise
    // saturates at MAX_WAIT, which holds stall_req until the head drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (store) begin
                tail <= tail + AW'(1);
            end
            if (grant_fifo) begin
                head <= head + AW'(1);
            end
            case ({store, grant_fifo})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (fifo_empty || grant_fifo) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WW'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    // Entry storage needs no reset: a slot is only read while count marks it live.
    always_ff @(posedge clk) begin
        if (store) begin
            num_mem[tail]  <= lu_num;
            data_mem[tail] <= lu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Directed walk through reset, idle drain, starvation stall, full FIFO, x0
// handling and hazard queries, followed by a randomized run. Every cycle
// all outputs are compared against a queue-based reference of the
// arbiter's rules; the directed steps add explicit constant checks.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_num;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_num;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  q_num1;
    logic [4:0]  q_num2;
    logic        q_hit1;
    logic        q_hit2;
    logic        stall_req;
    logic [2:0]  fifo_cnt;
    logic [4:0]  WriteBackNum;
    logic        WriteBackReg;
    logic [31:0] WriteBackData;

    int checks = 0;
    int fails  = 0;

    // Reference state: buffered results in arrival order plus the head's age.
    logic [4:0]  mNum[$];
    logic [31:0] mData[$];
    int          mWait;

    logic        expReady, expStall, expHit1, expHit2, expReg;
    logic [4:0]  expNum;
    logic [31:0] expData;
    logic        expStore, expPop;

    // Producer for the randomized phase: a result is offered until accepted.
    logic        pend;
    logic [4:0]  pendNum;
    logic [31:0] pendData;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_we       (pipe_we),
        .pipe_num      (pipe_num),
        .pipe_data     (pipe_data),
        .lu_valid      (lu_valid),
        .lu_num        (lu_num),
        .lu_data       (lu_data),
        .lu_ready      (lu_ready),
        .q_num1        (q_num1),
        .q_num2        (q_num2),
        .q_hit1        (q_hit1),
        .q_hit2        (q_hit2),
        .stall_req     (stall_req),
        .fifo_cnt      (fifo_cnt),
        .WriteBackNum  (WriteBackNum),
        .WriteBackReg  (WriteBackReg),
        .WriteBackData (WriteBackData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the current inputs, from the arbiter's rules.
    task automatic modelEval();
        int  n;
        logic pipeOk;
        n        = mNum.size();
        expReady = !rst && (n < DEPTH);
        expStore = lu_valid && expReady && (lu_num != 0);
        expStall = !rst && (n != 0) && (mWait == MAX_WAIT);
        pipeOk   = pipe_we && (pipe_num != 0);
        expPop   = !rst && (n != 0) && (expStall || !pipeOk);
        expReg   = 1'b0;
        expNum   = 5'd0;
        expData  = 32'd0;
        if (expPop) begin
            expReg  = 1'b1;
            expNum  = mNum[0];
            expData = mData[0];
        end else if (!rst && pipeOk) begin
            expReg  = 1'b1;
            expNum  = pipe_num;
            expData = pipe_data;
        end
        expHit1 = 1'b0;
        expHit2 = 1'b0;
        if (!rst) begin
            foreach (mNum[i]) begin
                if (q_num1 != 0 && mNum[i] == q_num1) expHit1 = 1'b1;
                if (q_num2 != 0 && mNum[i] == q_num2) expHit2 = 1'b1;
            end
            if (expStore && q_num1 != 0 && lu_num == q_num1) expHit1 = 1'b1;
            if (expStore && q_num2 != 0 && lu_num == q_num2) expHit2 = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic pwe, input logic [4:0] pnum,
                                 input logic [31:0] pdata, input logic lv, input logic [4:0] lnum,
                                 input logic [31:0] ldata, input logic [4:0] qn1, input logic [4:0] qn2);
        rst       = r;
        pipe_we   = pwe;
        pipe_num  = pnum;
        pipe_data = pdata;
        lu_valid  = lv;
        lu_num    = lnum;
        lu_data   = ldata;
        q_num1    = qn1;
        q_num2    = qn2;
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        modelEval();
        chk("lu_ready",      {31'd0, lu_ready},     {31'd0, expReady});
        chk("stall_req",     {31'd0, stall_req},    {31'd0, expStall});
        chk("fifo_cnt",      {29'd0, fifo_cnt},     rst ? 32'd0 : 32'(mNum.size()));
        chk("WriteBackReg",  {31'd0, WriteBackReg}, {31'd0, expReg});
        chk("WriteBackNum",  {27'd0, WriteBackNum}, {27'd0, expNum});
        chk("WriteBackData", WriteBackData,         expData);
        chk("q_hit1",        {31'd0, q_hit1},       {31'd0, expHit1});
        chk("q_hit2",        {31'd0, q_hit2},       {31'd0, expHit2});
    endtask

    // Clock edge: update the reference with the decisions made for this cycle.
    task automatic advance();
        bit wasEmpty;
        @(posedge clk);
        if (rst) begin
            mNum.delete();
            mData.delete();
            mWait = 0;
        end else begin
            wasEmpty = (mNum.size() == 0);
            if (expPop) begin
                void'(mNum.pop_front());
                void'(mData.pop_front());
            end
            if (expStore) begin
                mNum.push_back(lu_num);
                mData.push_back(lu_data);
            end
            if (wasEmpty || expPop) mWait = 0;
            else if (mWait < MAX_WAIT) mWait = mWait + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    task automatic drainAll();
        for (int i = 0; i < 2 * DEPTH + 2 && mNum.size() != 0; i++) begin
            idle();
            advance();
        end
        idle();
        chk("drain_empty", {29'd0, fifo_cnt}, 32'd0);
    endtask

    initial begin
        mWait = 0;
        pend  = 1'b0;
        pendNum  = 5'd0;
        pendData = 32'd0;
        @(negedge clk);

        // Reset held two cycles with a result offered: nothing may enter.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h4444, 5'd4, 5'd3);
            chk("rst_ready",  {31'd0, lu_ready},     32'd0);
            chk("rst_wbreg",  {31'd0, WriteBackReg}, 32'd0);
            chk("rst_wbnum",  {27'd0, WriteBackNum}, 32'd0);
            chk("rst_cnt",    {29'd0, fifo_cnt},     32'd0);
            chk("rst_hit1",   {31'd0, q_hit1},       32'd0);
            advance();
        end
        idle();
        chk("post_rst_ready", {31'd0, lu_ready}, 32'd1);
        chk("post_rst_cnt",   {29'd0, fifo_cnt}, 32'd0);

        // Idle drain: result appears on the port the next cycle.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        chk("push_no_bypass", {31'd0, WriteBackReg}, 32'd0);
        advance();
        idle();
        chk("drain_reg",  {31'd0, WriteBackReg}, 32'd1);
        chk("drain_num",  {27'd0, WriteBackNum}, 32'd5);
        chk("drain_data", WriteBackData,         32'hDEADBEEF);
        advance();
        idle();
        chk("drain_cnt", {29'd0, fifo_cnt}, 32'd0);

        // Starvation: pipe wins MAX_WAIT cycles, then the FIFO forces a stall.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 5'd0, 5'd0);
        advance();
        for (int c = 1; c <= MAX_WAIT + 2; c++) begin
            applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            chk("starve_stall", {31'd0, stall_req}, (c == MAX_WAIT + 1) ? 32'd1 : 32'd0);
            chk("starve_num",   {27'd0, WriteBackNum}, (c == MAX_WAIT + 1) ? 32'd7 : 32'd3);
            advance();
        end

        // Full FIFO with pipe busy; a fifth result waits for room.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'(i + 1), 32'hA000 + i, 5'd0, 5'd0);
            advance();
        end
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd20, 32'h5555, 5'd0, 5'd0);
        chk("full_cnt",   {29'd0, fifo_cnt}, 32'd4);
        chk("full_ready", {31'd0, lu_ready}, 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd20, 32'h5555, 5'd0, 5'd0);
        chk("refill_ready", {31'd0, lu_ready}, 32'd1);
        chk("refill_cnt",   {29'd0, fifo_cnt}, 32'd3);
        advance();
        drainAll();

        // x0: handshake without storage, and pipe x0 write yields to the FIFO.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0, 5'd0, 5'd0);
        chk("x0_ready", {31'd0, lu_ready}, 32'd1);
        advance();
        idle();
        chk("x0_cnt", {29'd0, fifo_cnt}, 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1010, 5'd0, 5'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("x0_pipe_num", {27'd0, WriteBackNum}, 32'd10);
        chk("x0_pipe_reg", {31'd0, WriteBackReg}, 32'd1);
        advance();

        // Queries against buffered and same-cycle results.
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd9, 32'h9999, 5'd0, 5'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        chk("q_fifo_hit1", {31'd0, q_hit1}, 32'd1);
        chk("q_zero_hit2", {31'd0, q_hit2}, 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd12, 32'hCCCC, 5'd9, 5'd12);
        chk("q_same_cycle_hit2", {31'd0, q_hit2}, 32'd1);
        advance();
        drainAll();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd12);
        chk("q_after_hit1", {31'd0, q_hit1}, 32'd0);
        chk("q_after_hit2", {31'd0, q_hit2}, 32'd0);
        advance();

        // Reset mid-operation drops buffered results.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'(i + 14), 32'hE000 + i, 5'd0, 5'd0);
            advance();
        end
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 5'd14, 5'd0);
        advance();
        idle();
        chk("mid_rst_cnt", {29'd0, fifo_cnt}, 32'd0);
        advance();

        // Randomized traffic with a holding producer.
        for (int c = 0; c < 600; c++) begin
            logic r;
            if (!pend && $urandom_range(0, 9) < 6) begin
                pend     = 1'b1;
                pendNum  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                pendData = $urandom;
            end
            r = ($urandom_range(0, 79) == 0);
            applyStimulus(r, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                          pend, pendNum, pendData,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (pend && expReady) pend = 1'b0;
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
